dino_game_ctrl: RTL
===================

Name: dino_game_ctrl

Overview:
- Owns the game_status signal that the jump logic consumes; it is the writer side of that interface.
- Reads dinosaur_height, which the jump logic produces, and the obstacle position. Detects dinosaur/obstacle collisions and runs the IDLE/RUN/OVER game state machine.
- Keeps a running score and exposes both to the display path.

Parameters:
- X_W, 8: width of obstacle_x.
- DINO_X, 16: left edge x of the dinosaur (fixed column).
- DINO_W, 8: dinosaur width in x units.
- OBST_W, 6: obstacle width in x units.
- CLEAR_Y, 40: dinosaur_height at or below this value clears any obstacle. Height 63 = ground, smaller = higher.
- HIT_FILTER, 2: consecutive colliding ticks needed to end the game (1..15).
- SCORE_W, 16: score width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- button_start  in  1  raw start/restart button, synchronous to CLK, level.
- tick  in  1  one-cycle frame strobe; all game updates happen on tick.
- dinosaur_height  in  6  dinosaur vertical position from the jump logic.
- obstacle_valid  in  1  an obstacle is on screen.
- obstacle_x  in  X_W  obstacle left edge x.
- game_status  out  1  1 while in RUN, else 0.
- game_over  out  1  1 while in OVER.
- score  out  SCORE_W  ticks survived in the current or last game.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, game_status=0, game_over=0, score=0.
  - hit_cnt=0, start_q=0.
  - Outputs take these values immediately; RTL releases synchronously on the next CLK edge after RST_N=1.
- Start edge:
  - start_q <= button_start every cycle.
  - start_edge = button_start & ~start_q.
  - Holding the button gives exactly one edge.
- Overlap:
  - overlap = (obstacle_x + OBST_W > DINO_X) && (obstacle_x < DINO_X + DINO_W).
  - Computed in X_W+1 bits, so no wrap at obstacle_x near max.
  - Edge-touching case obstacle_x+OBST_W == DINO_X is no overlap.
- Collision:
  - hit = obstacle_valid && overlap && (dinosaur_height > CLEAR_Y).
  - Combinational; sampled only on tick.
- State IDLE:
  - start_edge → RUN next cycle; score<=0, hit_cnt<=0.
  - tick is ignored.
- State RUN:
  - On tick with hit: hit_cnt<=hit_cnt+1. If hit_cnt+1 == HIT_FILTER → OVER; score is not incremented on that tick.
  - On tick with !hit: hit_cnt<=0 and score<=score+1, saturating at all-ones (no wrap).
  - start_edge is ignored in RUN.
- State OVER:
  - score is frozen.
  - start_edge → RUN; score<=0, hit_cnt<=0.
  - A start_edge and a tick in the same cycle: the transition wins and the tick is ignored.
- Output timing:
  - game_status and game_over are registered, decoded from state.
  - Latency: game_status falls on the CLK edge that consumes the terminal colliding tick, so it is low from the cycle after that tick.
  - game_status rises on the CLK edge that consumes start_edge.
- Invariant: game_status and game_over are never both 1.
- tick while RST_N=0 has no effect.

Optional Feature:
- Macro: DINO_HIGH_SCORE_EN.
- When defined:
  - Adds output high_score (SCORE_W).
  - Reset value of high_score is 0.
  - On entry to OVER, high_score <= max(high_score, final score).
  - high_score is not cleared on restart.
- When undefined: no port, no register; all other behaviour is identical.

Test Plan:
- Reset, then button_start held 1 for 5 cycles → exactly one RUN entry; game_status=1 the cycle after first press; score=0.
- RUN, 10 ticks with obstacle_valid=0 → score=10, game_status stays 1.
- RUN, obstacle_x=14, dinosaur_height=63, HIT_FILTER=2, two consecutive ticks:
  - After 1st tick: still RUN, score unchanged.
  - After 2nd tick: game_over=1, game_status=0, score frozen.
- RUN, obstacle_x=14 with dinosaur_height=63 on 1 tick, then dinosaur_height=5 on the next 3 ticks → no OVER; score +3; hit_cnt cleared.
- Boundary: obstacle_x=10 (10+6==16) and obstacle_x=24 (==DINO_X+DINO_W), both with height 63 → no collision over 4 ticks.
  - obstacle_x=250 → no false overlap from wrap.
- OVER, press start → RUN, score=0.
  - With DINO_HIGH_SCORE_EN: games of 12 then 7 ticks → high_score=12.
  - Also assert RST_N low mid-RUN → game_status=0 and score=0 immediately.

Source files
------------

// File: rtl/dino_game_ctrl.sv
// Dino game controller: start-edge detect, collision filter, IDLE/RUN/OVER FSM, score.
// Optional high_score register and port behind DINO_HIGH_SCORE_EN.
module dino_game_ctrl #(
    parameter int X_W        = 8,
    parameter int DINO_X     = 16,
    parameter int DINO_W     = 8,
    parameter int OBST_W     = 6,
    parameter int CLEAR_Y    = 40,
    parameter int HIT_FILTER = 2,
    parameter int SCORE_W    = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               button_start,
    input  logic               tick,
    input  logic [5:0]         dinosaur_height,
    input  logic               obstacle_valid,
    input  logic [X_W-1:0]     obstacle_x,
    output logic               game_status,
    output logic               game_over,
`ifdef DINO_HIGH_SCORE_EN
    output logic [SCORE_W-1:0] high_score,
`endif
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [X_W:0]         OBST_W_X = (X_W+1)'(OBST_W);
    localparam logic [X_W:0]         LEFT_X   = (X_W+1)'(DINO_X);
    localparam logic [X_W:0]         RIGHT_X  = (X_W+1)'(DINO_X + DINO_W);
    localparam logic [5:0]           CLEAR_H  = 6'(CLEAR_Y);
    localparam logic [3:0]           FILT     = 4'(HIT_FILTER);
    localparam logic [SCORE_W-1:0]   SC_MAX   = {SCORE_W{1'b1}};

    state_t               state_q, state_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           hit_cnt_q, hit_cnt_d;
    logic [3:0]           hit_inc;
    logic                 start_q;
    logic                 game_status_q, game_status_d;
    logic                 game_over_q, game_over_d;
    logic                 start_edge;
    logic [X_W:0]         ox_ext;
    logic                 overlap;
    logic                 hit;

    // One bit of headroom so obstacle_x + OBST_W cannot wrap near max x
    assign ox_ext     = {1'b0, obstacle_x};
    assign overlap    = ((ox_ext + OBST_W_X) > LEFT_X) && (ox_ext < RIGHT_X);
    assign hit        = obstacle_valid && overlap && (dinosaur_height > CLEAR_H);
    assign start_edge = button_start & ~start_q;
    assign hit_inc    = hit_cnt_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        hit_cnt_d = hit_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d   = RUN;
                    score_d   = '0;
                    hit_cnt_d = '0;
                end
            end
            RUN: begin
                if (tick) begin
                    if (hit) begin
                        hit_cnt_d = hit_inc;
                        if (hit_inc == FILT) begin
                            state_d = OVER;
                        end
                    end else begin
                        hit_cnt_d = '0;
                        if (score_q != SC_MAX) begin
                            score_d = score_q + 1'b1;
                        end
                    end
                end
            end
            OVER: begin
                if (start_edge) begin
                    state_d   = RUN;
                    score_d   = '0;
                    hit_cnt_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                score_d   = '0;
                hit_cnt_d = '0;
            end
        endcase
        game_status_d = (state_d == RUN);
        game_over_d   = (state_d == OVER);
    end

`ifdef DINO_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_score_q, high_score_d;

    always_comb begin
        high_score_d = high_score_q;
        if ((state_q == RUN) && (state_d == OVER) && (score_q > high_score_q)) begin
            high_score_d = score_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            high_score_q <= '0;
        end else begin
            high_score_q <= high_score_d;
        end
    end

    assign high_score = high_score_q;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            score_q       <= '0;
            hit_cnt_q     <= '0;
            start_q       <= 1'b0;
            game_status_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            hit_cnt_q     <= hit_cnt_d;
            start_q       <= button_start;
            game_status_q <= game_status_d;
            game_over_q   <= game_over_d;
        end
    end

    assign game_status = game_status_q;
    assign game_over   = game_over_q;
    assign score       = score_q;

endmodule
